// File: rtl/demux_pkg.sv
// Shared helpers for the demux slice.
// sel_width() derives the selector width from the output count.
package demux_pkg;

   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/demux_if.sv
// Decoder bus: the binary request (enable/selector) and its one-hot result.
// The master drives the request; the slave (the decoder) drives out.
interface demux_if
   import demux_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 8
);
   localparam int SELECTOR_WIDTH = sel_width(OUTPUT_WIDTH);

   logic                      enable;
   logic [SELECTOR_WIDTH-1:0] selector;
   logic [OUTPUT_WIDTH-1:0]   out;

   modport master (output enable, output selector, input out);
   modport slave  (input enable, input selector, output out);
endinterface

// File: rtl/demux_onehot_decode.sv
// Combinational 1-of-N decoder built from per-bit equality compares.
// Selector values >= OUTPUT_WIDTH match no bit, so out stays all zero.
module onehot_decode #(
   parameter int OUTPUT_WIDTH   = 8,
   parameter int SELECTOR_WIDTH = 3
) (
   input  logic                      enable,
   input  logic [SELECTOR_WIDTH-1:0] selector,
   output logic [OUTPUT_WIDTH-1:0]   dec
);

   for (genvar k = 0; k < OUTPUT_WIDTH; k++) begin : g_bit
      assign dec[k] = enable && (selector == SELECTOR_WIDTH'(k));
   end

endmodule

// File: rtl/demux.sv
// Parameterised 1-of-N demultiplexer with optional registered output.
// With REGISTER_OUTPUT=0 clk and rst_n are ignored.
module demux
   import demux_pkg::*;
#(
   parameter int OUTPUT_WIDTH    = 8,
   parameter bit REGISTER_OUTPUT = 1'b0
) (
   input logic    clk,
   input logic    rst_n,
   demux_if.slave bus
);
   localparam int SELECTOR_WIDTH = sel_width(OUTPUT_WIDTH);

   if (OUTPUT_WIDTH < 1) begin : g_bad_width
      $fatal(1, "demux: OUTPUT_WIDTH must be at least 1");
   end

   logic [OUTPUT_WIDTH-1:0] dec;

   onehot_decode #(
      .OUTPUT_WIDTH  (OUTPUT_WIDTH),
      .SELECTOR_WIDTH(SELECTOR_WIDTH)
   ) u_decode (
      .enable  (bus.enable),
      .selector(bus.selector),
      .dec     (dec)
   );

   if (REGISTER_OUTPUT) begin : g_reg
      logic [OUTPUT_WIDTH-1:0] out_d, out_q;

      assign out_d = dec;

      always_ff @(posedge clk) begin
         if (!rst_n) out_q <= '0;
         else        out_q <= out_d;
      end

      assign bus.out = out_q;
   end else begin : g_comb
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst_n;
      assign bus.out        = dec;
   end

endmodule

// File: tb/tb_demux.sv
// Bench for demux: wide combinational, single-line, and registered variants
// compared against a bit-set reference model.
module tb_demux;
   localparam int W = 1025;
   typedef logic [W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   demux_if #(.OUTPUT_WIDTH(1025)) bus_w ();
   demux_if #(.OUTPUT_WIDTH(1))    bus_1 ();
   demux_if #(.OUTPUT_WIDTH(8))    bus_r ();

   demux #(.OUTPUT_WIDTH(1025), .REGISTER_OUTPUT(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
   demux #(.OUTPUT_WIDTH(1),    .REGISTER_OUTPUT(1'b0)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(bus_1));
   demux #(.OUTPUT_WIDTH(8),    .REGISTER_OUTPUT(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));

   // Reference: one line set at index sel when enabled and sel names a real line.
   function automatic vec_t ref_dec(input int n, input bit en, input int sel);
      vec_t r = '0;
      if (en && sel < n) r[sel] = 1'b1;
      return r;
   endfunction

   function automatic int low_bit(input vec_t v);
      for (int i = 0; i < W; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got ones=%0d low=%0d, want ones=%0d low=%0d",
                  tag, $countones(got), low_bit(got), $countones(exp), low_bit(exp));
      end
   endtask

   task automatic drive_w(input bit en, input int sel);
      bus_w.enable   = en;
      bus_w.selector = 11'(sel);
      #1;
      check($sformatf("w1025 en=%0d sel=%0d", en, sel), bus_w.out, ref_dec(1025, en, sel));
   endtask

   task automatic drive_1(input bit en, input int sel);
      bus_1.enable   = en;
      bus_1.selector = 1'(sel);
      #1;
      check($sformatf("w1 en=%0d sel=%0d", en, sel), W'(bus_1.out), ref_dec(1, en, sel));
   endtask

   task automatic reg_edge(input string tag, input vec_t exp);
      @(posedge clk);
      #1;
      check(tag, W'(bus_r.out), exp);
   endtask

   initial begin
      bit en;
      int sel;
      bit rst;
      vec_t exp;

      rst_n          = 1'b0;
      bus_r.enable   = 1'b1;
      bus_r.selector = 3'd3;

      // Full sweep, enable high then dropped after each check.
      for (int s = 0; s < 1025; s++) begin
         drive_w(1'b1, s);
         drive_w(1'b0, s);
      end
      drive_w(1'b1, 1025);
      drive_w(1'b1, 2047);
      for (int i = 0; i < 300; i++) drive_w(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)));

      drive_1(1'b1, 0);
      drive_1(1'b1, 1);
      drive_1(1'b0, 0);
      drive_1(1'b0, 1);

      // Registered variant: reset held, release, retarget, mid-run reset.
      @(negedge clk);
      rst_n = 1'b0;
      bus_r.enable = 1'b1;
      bus_r.selector = 3'd3;
      for (int i = 0; i < 3; i++) reg_edge($sformatf("reset hold %0d", i), '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release before edge", W'(bus_r.out), '0);
      reg_edge("release sel=3", ref_dec(8, 1'b1, 3));
      @(negedge clk);
      bus_r.selector = 3'd7;
      reg_edge("sel=7", ref_dec(8, 1'b1, 7));
      @(negedge clk);
      rst_n = 1'b0;
      reg_edge("mid reset", '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid release before edge", W'(bus_r.out), '0);
      reg_edge("resume sel=7", ref_dec(8, 1'b1, 7));

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         en  = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 7));
         rst = ($urandom_range(0, 9) == 0);
         bus_r.enable   = en;
         bus_r.selector = 3'(sel);
         rst_n          = !rst;
         exp = rst ? '0 : ref_dec(8, en, sel);
         reg_edge($sformatf("reg rnd %0d en=%0d sel=%0d rst=%0d", i, en, sel, rst), exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (n_err != 0) $fatal(1, "demux bench saw miscompares");
      $finish;
   end

endmodule
